// File: rtl/face_det_pkg.sv
// Shared definitions for the face-detector control path.
// Holds the 3-bit sequencer state codes and the state width. The window
// scanner, stage evaluator and top-level monitor import this package so
// they all decode the exported `state` bus the same way.
package face_det_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE             = 3'd0;
  localparam logic [STATE_W-1:0] ST_COMPUTE_INTEGRAL = 3'd1;
  localparam logic [STATE_W-1:0] ST_INIT_SCAN        = 3'd2;
  localparam logic [STATE_W-1:0] ST_EVAL_CASCADE     = 3'd3;
  localparam logic [STATE_W-1:0] ST_NEXT_STAGE       = 3'd4;
  localparam logic [STATE_W-1:0] ST_NEXT_WINDOW      = 3'd5;
  localparam logic [STATE_W-1:0] ST_FINISH           = 3'd6;

  // Code 7 is deliberately left out of the enum; the sequencer treats it
  // as illegal and recovers to IDLE.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE             = ST_IDLE,
    S_COMPUTE_INTEGRAL = ST_COMPUTE_INTEGRAL,
    S_INIT_SCAN        = ST_INIT_SCAN,
    S_EVAL_CASCADE     = ST_EVAL_CASCADE,
    S_NEXT_STAGE       = ST_NEXT_STAGE,
    S_NEXT_WINDOW      = ST_NEXT_WINDOW,
    S_FINISH           = ST_FINISH
  } state_e;

endpackage

// File: rtl/control_fsm.sv
// control_fsm: top-level sequencer for the Haar-cascade face detector.
//
// Waits for start, has the integral image built, then walks detection
// windows evaluating cascade stages. Ends in FINISH on the first window
// that passes every stage, or once the last window fails.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   begin a run (looked at only in IDLE and FINISH)
//   ii_done      in   integral image ready (only in COMPUTE_INTEGRAL)
//   stage_done   in   stage result valid (only in EVAL_CASCADE)
//   stage_passed in   stage passed, qualified by stage_done
//   last_stage   in   final cascade stage, qualified by stage_done
//   last_window  in   final scan window, qualified by stage_done
//   state        out  current state code (face_det_pkg encoding)
//   stage_start  out  one-cycle strobe on every entry into EVAL_CASCADE
//   next_window  out  high while in NEXT_WINDOW
//
// Strobe semantics: there is no back-pressure. stage_done is a
// single-cycle valid from the evaluator; if it is held high, each
// EVAL_CASCADE cycle that sees it counts as a fresh result.
module control_fsm
  import face_det_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               ii_done,
  input  logic               stage_done,
  input  logic               stage_passed,
  input  logic               last_stage,
  input  logic               last_window,
  output logic [STATE_W-1:0] state,
  output logic               stage_start,
  output logic               next_window
);

  state_e r_state;
  state_e w_next;
  logic   r_stage_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_stage_start <= 1'b0;
    end else begin
      r_state       <= w_next;
      // Pulse only on an entry edge into EVAL_CASCADE, never while held.
      r_stage_start <= (w_next == S_EVAL_CASCADE) && (r_state != S_EVAL_CASCADE);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:             if (start)   w_next = S_COMPUTE_INTEGRAL;
      S_COMPUTE_INTEGRAL: if (ii_done) w_next = S_INIT_SCAN;
      S_INIT_SCAN:        w_next = S_EVAL_CASCADE;
      S_EVAL_CASCADE: begin
        if (stage_done) begin
          if (stage_passed) w_next = last_stage  ? S_FINISH : S_NEXT_STAGE;
          else              w_next = last_window ? S_FINISH : S_NEXT_WINDOW;
        end
      end
      S_NEXT_STAGE:       w_next = S_EVAL_CASCADE;
      S_NEXT_WINDOW:      w_next = S_EVAL_CASCADE;
      S_FINISH:           if (start)   w_next = S_COMPUTE_INTEGRAL;
      default:            w_next = S_IDLE;
    endcase
  end

  assign state       = r_state;
  assign stage_start = r_stage_start;
  assign next_window = (r_state == S_NEXT_WINDOW);

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, ii_done, stage_done, stage_passed, last_stage, last_window;
  logic [2:0] state;
  logic       stage_start, next_window;

  control_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ii_done      (ii_done),
    .stage_done   (stage_done),
    .stage_passed (stage_passed),
    .last_stage   (last_stage),
    .last_window  (last_window),
    .state        (state),
    .stage_start  (stage_start),
    .next_window  (next_window)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst_n;
    logic       start, ii_done, stage_done, stage_passed, last_stage, last_window;
    logic [2:0] exp_state;
    logic       exp_ss, exp_nw;
  } vec_t;

  vec_t tbl[$];

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard queue for the random phase: {state, stage_start, next_window}
  logic [4:0] exp_q[$];

  // Reference model state, tracked with the specification's numeric codes.
  int m_state;

  function automatic vec_t mk(input logic r, st, ii, sd, sp, ls, lw,
                              input logic [2:0] es, input logic ess, enw);
    vec_t v;
    v.rst_n = r; v.start = st; v.ii_done = ii; v.stage_done = sd;
    v.stage_passed = sp; v.last_stage = ls; v.last_window = lw;
    v.exp_state = es; v.exp_ss = ess; v.exp_nw = enw;
    return v;
  endfunction

  // Next state from the rule list: which input matters depends only on
  // where the sequencer is, everything else is ignored.
  function automatic int model_next(input int s, input logic r, st, ii, sd, sp, ls, lw);
    if (!r) return 0;
    if (s == 0 || s == 6) return st ? 1 : s;
    if (s == 1) return ii ? 2 : 1;
    if (s == 2 || s == 4 || s == 5) return 3;
    if (s == 3) begin
      if (!sd) return 3;
      if (sp)  return ls ? 6 : 4;
      return lw ? 6 : 5;
    end
    return 0;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, st, ii, sd, sp, ls, lw);
    rst_n = r; start = st; ii_done = ii; stage_done = sd;
    stage_passed = sp; last_stage = ls; last_window = lw;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] es, input logic ess, enw);
    n_vec++;
    if (state !== es) begin
      n_err++;
      $display("FAIL %s: state=%0d expected %0d", name, state, es);
    end
    if (stage_start !== ess) begin
      n_err++;
      $display("FAIL %s: stage_start=%0b expected %0b", name, stage_start, ess);
    end
    if (next_window !== enw) begin
      n_err++;
      $display("FAIL %s: next_window=%0b expected %0b", name, next_window, enw);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    rst_n = 1'b0; start = 0; ii_done = 0; stage_done = 0;
    stage_passed = 0; last_stage = 0; last_window = 0;
    #1;

    // reset and idle
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0,0,0,0,0,0,0, 3'd0,0,0));
    for (int i = 0; i < 5;  i++) tbl.push_back(mk(1,0,0,0,0,0,0, 3'd0,0,0));
    // ignored strobes in IDLE
    tbl.push_back(mk(1,0,1,0,0,0,0, 3'd0,0,0));
    tbl.push_back(mk(1,0,0,1,1,1,1, 3'd0,0,0));
    // start, hold in COMPUTE_INTEGRAL, start ignored there
    tbl.push_back(mk(1,1,0,0,0,0,0, 3'd1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 3'd1,0,0));
    tbl.push_back(mk(1,1,0,1,1,0,0, 3'd1,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,0, 3'd2,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 3'd3,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 3'd3,0,0));
    tbl.push_back(mk(1,1,1,0,0,0,0, 3'd3,0,0));
    // five passed stages
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk(1,0,0,1,1,0,0, 3'd4,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd3,1,0));
    end
    // five failed windows
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk(1,0,0,1,0,0,0, 3'd5,0,1));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd3,1,0));
    end
    // held-high stage_done re-evaluates on every EVAL cycle
    tbl.push_back(mk(1,0,0,1,0,0,0, 3'd5,0,1));
    tbl.push_back(mk(1,0,0,1,0,0,0, 3'd3,1,0));
    tbl.push_back(mk(1,0,0,1,0,0,0, 3'd5,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0, 3'd3,1,0));
    // last window fails: scan exhausted, FINISH holds
    tbl.push_back(mk(1,0,0,1,0,0,1, 3'd6,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 3'd6,0,0));
    tbl.push_back(mk(1,0,1,1,1,0,0, 3'd6,0,0));
    // restart from FINISH, face found on the first stage
    tbl.push_back(mk(1,1,0,0,0,0,0, 3'd1,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,0, 3'd2,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 3'd3,1,0));
    tbl.push_back(mk(1,0,0,1,1,1,0, 3'd6,0,0));
    // mid-run reset in NEXT_STAGE, then rerun
    tbl.push_back(mk(1,1,0,0,0,0,0, 3'd1,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,0, 3'd2,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 3'd3,1,0));
    tbl.push_back(mk(1,0,0,1,1,0,0, 3'd4,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 3'd0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0, 3'd0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, 3'd1,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,0, 3'd2,0,0));
    // reset in INIT_SCAN suppresses the pending stage_start
    tbl.push_back(mk(0,0,0,0,0,0,0, 3'd0,0,0));
    // reset in NEXT_WINDOW drops next_window
    tbl.push_back(mk(1,1,0,0,0,0,0, 3'd1,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,0, 3'd2,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 3'd3,1,0));
    tbl.push_back(mk(1,0,0,1,0,0,0, 3'd5,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 3'd0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].start, tbl[i].ii_done, tbl[i].stage_done,
            tbl[i].stage_passed, tbl[i].last_stage, tbl[i].last_window);
      check($sformatf("table[%0d]", i), tbl[i].exp_state, tbl[i].exp_ss, tbl[i].exp_nw);
    end

    // random phase against the reference model; DUT is in IDLE here
    m_state = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r, st, ii, sd, sp, ls, lw;
      int nx;
      logic [4:0] e;
      r  = ($urandom_range(0, 79) != 0);
      st = ($urandom_range(0, 3) == 0);
      ii = ($urandom_range(0, 2) == 0);
      sd = ($urandom_range(0, 1) == 0);
      sp = ($urandom_range(0, 3) != 0);
      ls = ($urandom_range(0, 5) == 0);
      lw = ($urandom_range(0, 5) == 0);
      nx = model_next(m_state, r, st, ii, sd, sp, ls, lw);
      e[4:2] = 3'(nx);
      e[1]   = r && (nx == 3) && (m_state != 3);
      e[0]   = (nx == 5);
      exp_q.push_back(e);
      m_state = nx;
      drive(r, st, ii, sd, sp, ls, lw);
      e = exp_q.pop_front();
      check($sformatf("random[%0d]", i), e[4:2], e[1], e[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
